// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch definitions: FSM state encoding and default reset PC / HALT encoding.
// Pure declarations; no timing or flow-control behaviour of its own.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    localparam logic [7:0]  DEF_RESET_PC   = 8'h00;
    localparam logic [31:0] DEF_HALT_INSTR = 32'h0000_007F;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch -> decode handshake: head {pc, instr} offered on out_valid, taken on out_ready.
// The master holds the head stable until out_ready is seen with out_valid high.
interface fetch_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
);
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_sequencer_queue.sv
// In-order fetch queue with synchronous flush; push lands one edge later, head read combinationally.
// No internal backpressure: the owner must only push when not full or when popping in the same cycle.
module fetch_sequencer_queue #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head_dat,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, drives the ROM address and queues {pc, instr} for decode; ROM->queue 0 cycles, queue->out 1.
// Stalls (pc holds) when the queue is full and decode is not taking; redirect flushes and restarts fetch.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                 PC_W       = 8,
    parameter int                 INSTR_W    = 32,
    parameter int                 QDEPTH     = 4,
    parameter logic [PC_W-1:0]    RESET_PC   = PC_W'(DEF_RESET_PC),
    parameter bit                 HALT_EN    = 1'b1,
    parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(DEF_HALT_INSTR)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [PC_W-1:0]         o_rom_addr,
    input  logic [INSTR_W-1:0]      i_rom_data,
    input  logic                    i_redirect_valid,
    input  logic [PC_W-1:0]         i_redirect_pc,
    fetch_sequencer_if.master       dec,
    output logic [$clog2(QDEPTH):0] o_q_count,
    output logic                    o_halted
);
    localparam int                CNT_W    = $clog2(QDEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(QDEPTH);

    fetch_state_e             r_state;
    logic [PC_W-1:0]          r_pc;
    logic                     r_halted;

    logic [CNT_W-1:0]         w_count;
    logic [PC_W+INSTR_W-1:0]  w_head;
    logic                     w_redirect;
    logic                     w_out_valid;
    logic                     w_deq;
    logic                     w_space;
    logic                     w_enq;
    logic                     w_is_halt;

    // A redirect while still booting is dropped; once running it wins over everything.
    assign w_redirect  = i_redirect_valid && (r_state != S_BOOT);
    assign w_out_valid = (w_count != '0) && !i_redirect_valid;
    assign w_deq       = w_out_valid && dec.out_ready;
    assign w_space     = (w_count != FULL_CNT) || w_deq;
    assign w_enq       = (r_state == S_RUN) && w_space && !w_redirect;
    assign w_is_halt   = HALT_EN && (i_rom_data == HALT_INSTR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_BOOT;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else if (w_redirect) begin
            r_state  <= S_RUN;
            r_pc     <= i_redirect_pc;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // The HALT itself is queued; pc stays on it so the stop point is visible.
                    if (w_enq) begin
                        if (w_is_halt) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    fetch_sequencer_queue #(
        .W     (PC_W + INSTR_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_flush    (w_redirect),
        .i_push     (w_enq),
        .i_push_dat ({r_pc, i_rom_data}),
        .i_pop      (w_deq),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    assign o_rom_addr    = r_pc;
    assign dec.out_valid = w_out_valid;
    assign dec.out_pc    = w_head[PC_W+INSTR_W-1 -: PC_W];
    assign dec.out_instr = w_head[INSTR_W-1:0];
    assign o_q_count     = w_count;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle table for run/stall/redirect, hand sequences for wrap, halt, async reset.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [2:0]  q_count;
    logic        halted;
    logic        halt_mode;

    logic [7:0]  rom2_addr;
    logic [31:0] rom2_data;
    logic [2:0]  q2_count;
    logic        halted2;

    int n_pass;
    int n_total;

    fetch_sequencer_if #(.PC_W(8), .INSTR_W(32)) dec_if ();
    fetch_sequencer_if #(.PC_W(8), .INSTR_W(32)) wrap_if ();

    assign rom_data  = (halt_mode && rom_addr == 8'd5) ? 32'h0000_007F : 32'h100 + {24'd0, rom_addr};
    assign rom2_data = 32'h100 + {24'd0, rom2_addr};
    assign wrap_if.out_ready = 1'b1;

    fetch_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .o_rom_addr       (rom_addr),
        .i_rom_data       (rom_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .dec              (dec_if),
        .o_q_count        (q_count),
        .o_halted         (halted)
    );

    fetch_sequencer #(.RESET_PC(8'hFE), .HALT_EN(1'b0)) dut_wrap (
        .clk              (clk),
        .reset_n          (reset_n),
        .o_rom_addr       (rom2_addr),
        .i_rom_data       (rom2_data),
        .i_redirect_valid (1'b0),
        .i_redirect_pc    (8'h00),
        .dec              (wrap_if),
        .o_q_count        (q2_count),
        .o_halted         (halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       rdy;
        logic       rvld;
        logic [7:0] rpc;
        logic       exp_vld;
        logic [7:0] exp_pc;
        logic [2:0] exp_cnt;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic rdy, input logic rvld, input logic [7:0] rpc,
                       input logic ev, input logic [7:0] epc, input logic [2:0] ecnt, input logic [7:0] eaddr);
        vec_t v;
        v.rst_n = rst_n; v.rdy = rdy; v.rvld = rvld; v.rpc = rpc;
        v.exp_vld = ev; v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_addr = eaddr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Leaves the caller just after the releasing negedge (edge 1 still ahead).
    task automatic reset_release();
        @(negedge clk);
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        dec_if.out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  wrap_exp [4];
        logic [7:0]  got_pc [$];
        logic [31:0] got_instr [$];

        n_pass = 0;
        n_total = 0;
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        halt_mode = 1'b0;
        dec_if.out_ready = 1'b1;

        // Reset, then streaming with out_ready=1.
        add(0, 1, 0, 8'h00, 0, 8'h00, 3'd0, 8'h00);
        add(0, 1, 0, 8'h00, 0, 8'h00, 3'd0, 8'h00);
        add(1, 1, 0, 8'h00, 0, 8'h00, 3'd0, 8'h00);
        add(1, 1, 0, 8'h00, 0, 8'h00, 3'd0, 8'h00);
        for (int k = 2; k < 8; k++) add(1, 1, 0, 8'h00, 1, 8'(k - 2), 3'd1, 8'(k - 1));
        // Back-pressure: fill to 4, stall at address 4, then drain pcs 0..7.
        add(0, 1, 0, 8'h00, 0, 8'h00, 3'd0, 8'h00);
        add(1, 0, 0, 8'h00, 0, 8'h00, 3'd0, 8'h00);
        add(1, 0, 0, 8'h00, 0, 8'h00, 3'd0, 8'h00);
        add(1, 0, 0, 8'h00, 1, 8'h00, 3'd1, 8'h01);
        add(1, 0, 0, 8'h00, 1, 8'h00, 3'd2, 8'h02);
        add(1, 0, 0, 8'h00, 1, 8'h00, 3'd3, 8'h03);
        for (int k = 5; k < 12; k++) add(1, 0, 0, 8'h00, 1, 8'h00, 3'd4, 8'h04);
        for (int k = 12; k < 20; k++) add(1, 1, 0, 8'h00, 1, 8'(k - 12), 3'd4, 8'(k - 8));
        // Redirect in BOOT is ignored; redirect to 0x40 with three entries queued.
        add(0, 1, 0, 8'h00, 0, 8'h00, 3'd0, 8'h00);
        add(1, 0, 1, 8'h80, 0, 8'h00, 3'd0, 8'h00);
        add(1, 0, 0, 8'h00, 0, 8'h00, 3'd0, 8'h00);
        add(1, 0, 0, 8'h00, 1, 8'h00, 3'd1, 8'h01);
        add(1, 0, 0, 8'h00, 1, 8'h00, 3'd2, 8'h02);
        add(1, 1, 1, 8'h40, 0, 8'h00, 3'd3, 8'h03);
        add(1, 1, 0, 8'h00, 0, 8'h00, 3'd0, 8'h40);
        add(1, 1, 0, 8'h00, 1, 8'h40, 3'd1, 8'h41);
        add(1, 1, 0, 8'h00, 1, 8'h41, 3'd1, 8'h42);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n = vecs[i].rst_n;
            dec_if.out_ready = vecs[i].rdy;
            redirect_valid = vecs[i].rvld;
            redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(dec_if.out_valid), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d q_count", i), 32'(q_count), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d halted", i), 32'(halted), 32'd0);
            if (vecs[i].exp_vld) begin
                check($sformatf("vec%0d out_pc", i), 32'(dec_if.out_pc), 32'(vecs[i].exp_pc));
                check($sformatf("vec%0d out_instr", i), dec_if.out_instr, 32'h100 + 32'(vecs[i].exp_pc));
            end
        end

        // PC wrap on the second instance (RESET_PC=FE).
        wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
        reset_release();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("wrap q_count", 32'(q2_count), 32'd1);
        check("wrap halted", 32'(halted2), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap%0d out_valid", i), 32'(wrap_if.out_valid), 32'd1);
            check($sformatf("wrap%0d out_pc", i), 32'(wrap_if.out_pc), 32'(wrap_exp[i]));
            check($sformatf("wrap%0d out_instr", i), wrap_if.out_instr, 32'h100 + 32'(wrap_exp[i]));
            @(negedge clk);
            #1;
        end

        // HALT at address 5: deliver 0..5, then stop until a redirect.
        halt_mode = 1'b1;
        reset_release();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (dec_if.out_valid) begin
                got_pc.push_back(dec_if.out_pc);
                got_instr.push_back(dec_if.out_instr);
            end
        end
        check("halt delivered count", 32'(got_pc.size()), 32'd6);
        for (int i = 0; i < got_pc.size(); i++)
            check($sformatf("halt pc%0d", i), 32'(got_pc[i]), 32'(i));
        if (got_instr.size() == 6) check("halt instr", got_instr[5], 32'h0000_007F);
        check("halt halted", 32'(halted), 32'd1);
        check("halt rom_addr", 32'(rom_addr), 32'd5);
        check("halt q_count", 32'(q_count), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        #1;
        check("halt redir out_valid", 32'(dec_if.out_valid), 32'd0);
        check("halt redir halted before edge", 32'(halted), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("halt cleared", 32'(halted), 32'd0);
        check("halt resume rom_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        #1;
        check("halt resume out_valid", 32'(dec_if.out_valid), 32'd1);
        check("halt resume out_pc", 32'(dec_if.out_pc), 32'd0);
        check("halt resume instr", dec_if.out_instr, 32'h100);
        halt_mode = 1'b0;

        // Asynchronous reset mid-stream with two entries queued.
        reset_release();
        dec_if.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("arst pre q_count", 32'(q_count), 32'd2);
        check("arst pre out_valid", 32'(dec_if.out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst out_valid", 32'(dec_if.out_valid), 32'd0);
        check("arst q_count", 32'(q_count), 32'd0);
        check("arst rom_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dec_if.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("arst restart pc0", 32'(dec_if.out_pc), 32'd0);
        check("arst restart valid", 32'(dec_if.out_valid), 32'd1);
        @(negedge clk);
        #1;
        check("arst restart pc1", 32'(dec_if.out_pc), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
